// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and request field constants for the data memory controller
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: byte-wide storage, synchronous byte/word write, combinational big-endian four-byte read
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          word,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0] mem [DEPTH];
  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign rdata[31-8*i -: 8] = mem[addr + AW'(i)];
  end
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (word || i == 0) mem[addr + AW'(i)] <= word ? wdata[31-8*i -: 8] : wdata[7:0];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-state data memory controller; DMEM_ALIGN_CHECK_EN enables misaligned word detection
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        R,
  input  logic        MEM_Enable_signal,
  input  logic        MEM_RW_enable,
  input  logic        MEM_Size_enable,
  input  logic        MEM_load_instr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        ld_valid,
  output logic        align_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  logic [2:0] cnt;
  logic rw_q, size_q, ld_q, acc, we, mis, accept;
  logic [AW-1:0] a_q, a_in;
  logic [31:0] wd_q, arr_rd;
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];
  assign accept = state == IDLE && MEM_Enable_signal;
`ifdef DMEM_ALIGN_CHECK_EN
  assign a_in = addr[AW-1:0];
  assign mis  = size_q == SIZE_WORD && a_q[1:0] != 2'b00;
`else
  assign a_in = MEM_Size_enable == SIZE_WORD ? {addr[AW-1:2], 2'b00} : addr[AW-1:0];
  assign mis  = 1'b0;
`endif
  always_ff @(posedge clk)
    if (R) state <= IDLE;
    else   state <= nxt;
  always_comb
    nxt = state == IDLE ? (MEM_Enable_signal ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE) :
          state == WAIT ? (cnt == 3'd1 ? ACCESS : WAIT) : IDLE;
  always_comb begin
    busy = state != IDLE;
    acc  = state == ACCESS;
    we   = acc && !R && rw_q == RW_WRITE && !mis;
  end
  always_ff @(posedge clk)
    if (R) begin
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      ld_valid  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      done      <= acc;
      ld_valid  <= acc && rw_q == RW_READ && ld_q;
      align_err <= acc && mis;
      if (accept) begin
        a_q    <= a_in;
        wd_q   <= wdata;
        rw_q   <= MEM_RW_enable;
        size_q <= MEM_Size_enable;
        ld_q   <= MEM_load_instr;
        cnt    <= 3'(WAIT_CYCLES);
      end else if (state == WAIT) cnt <= cnt - 3'd1;
      if (acc && rw_q == RW_READ)
        rdata <= mis ? '0 : size_q == SIZE_WORD ? arr_rd : {24'b0, arr_rd[31:24]};
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .we   (we),
    .word (size_q == SIZE_WORD),
    .addr (a_q),
    .wdata(wd_q),
    .rdata(arr_rd)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vectors for data_mem_ctrl with one and zero wait states
module tb_data_mem_ctrl;
  logic clk = 1'b0, R = 1'b1, en1 = 1'b0, en0 = 1'b0, rw = 1'b0, sz = 1'b0, ld = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata1, rdata0;
  logic busy1, done1, ldv1, al1, busy0, done0, ldv0, al0;
  int nvec = 0, nerr = 0;
  logic [31:0] prev;
  always #5 clk = ~clk;
  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .R(R), .MEM_Enable_signal(en1), .MEM_RW_enable(rw), .MEM_Size_enable(sz),
    .MEM_load_instr(ld), .addr(addr), .wdata(wdata), .rdata(rdata1), .busy(busy1),
    .done(done1), .ld_valid(ldv1), .align_err(al1));
  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .R(R), .MEM_Enable_signal(en0), .MEM_RW_enable(rw), .MEM_Size_enable(sz),
    .MEM_load_instr(ld), .addr(addr), .wdata(wdata), .rdata(rdata0), .busy(busy0),
    .done(done0), .ld_valid(ldv0), .align_err(al0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic w, input logic s, input logic l,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_ld, input logic exp_al);
    int n;
    @(negedge clk);
    rw = w; sz = s; ld = l; addr = a; wdata = d; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    n = 1;
    while (!done1 && n < 20) begin
      chk({tag, ".busy_hi"}, busy1, 1);
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, 3);
    chk({tag, ".busy_lo"}, busy1, 0);
    chk({tag, ".rdata"}, rdata1, exp_rd);
    chk({tag, ".ld_valid"}, ldv1, exp_ld);
    chk({tag, ".align_err"}, al1, exp_al);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst.rdata", rdata1, 0);
    chk("rst.busy", busy1, 0);
    chk("rst.done", done1, 0);
    chk("rst.ld_valid", ldv1, 0);
    chk("rst.align_err", al1, 0);
    chk("rst0.rdata", rdata0, 0);
    chk("rst0.busy", busy0, 0);
    R = 1'b0;
    xfer("w_word10", 1, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    @(negedge clk);
    chk("done_one_cycle", done1, 0);
    xfer("r_word10", 0, 1, 1, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0);
    xfer("r_byte11", 0, 0, 0, 32'h11, 32'h0, 32'h000000AD, 0, 0);
    xfer("w_byte13", 1, 0, 0, 32'h13, 32'h00000055, 32'h000000AD, 0, 0);
    xfer("r_word10b", 0, 1, 1, 32'h10, 32'h0, 32'hDEADBE55, 1, 0);
    xfer("w_word40", 1, 1, 0, 32'h40, 32'h11223344, 32'hDEADBE55, 0, 0);
    @(negedge clk);
    rw = 0; sz = 1; ld = 1; addr = 32'h40; en1 = 1'b1;
    @(negedge clk);
    chk("tog.busy_wait", busy1, 1);
    rw = 1; addr = 32'h10; wdata = 32'h0;
    @(negedge clk);
    chk("tog.busy_access", busy1, 1);
    en1 = 1'b0;
    @(negedge clk);
    chk("tog.done", done1, 1);
    chk("tog.rdata", rdata1, 32'h11223344);
    chk("tog.ld_valid", ldv1, 1);
    xfer("tog.noside", 0, 1, 0, 32'h10, 32'h0, 32'hDEADBE55, 0, 0);
    xfer("w_word00", 1, 1, 0, 32'h0, 32'hCAFEF00D, 32'hDEADBE55, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    xfer("r_word102", 0, 1, 1, 32'h102, 32'h0, 32'h0, 1, 1);
    prev = 32'h0;
`else
    xfer("r_word102", 0, 1, 1, 32'h102, 32'h0, 32'hCAFEF00D, 1, 0);
    prev = 32'hCAFEF00D;
`endif
    xfer("w_word20", 1, 1, 0, 32'h20, 32'hA5A5A5A5, prev, 0, 0);
    @(negedge clk);
    rw = 1; sz = 1; ld = 0; addr = 32'h20; wdata = 32'h12345678; en1 = 1'b1;
    @(negedge clk);
    chk("abort.busy_wait", busy1, 1);
    R = 1'b1; en1 = 1'b0;
    @(negedge clk);
    R = 1'b0;
    chk("abort.busy", busy1, 0);
    chk("abort.done", done1, 0);
    chk("abort.rdata", rdata1, 0);
    chk("abort.ld_valid", ldv1, 0);
    chk("abort.align_err", al1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.no_done", done1, 0);
    end
    xfer("abort.r_word20", 0, 1, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, 0);
    @(negedge clk);
    rw = 0; sz = 0; ld = 1; addr = 32'h10; en0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("b2b.done", done0, (k % 2 == 0));
      chk("b2b.busy", busy0, (k % 2 == 1));
      chk("b2b.excl", busy0 & done0, 0);
    end
    en0 = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, 256, byte capacity of the data array (power of two).
REQ-002 Parameter WAIT_CYCLES, 1, added wait states per access (range 0-7).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 R  input  1  reset, synchronous, active-high.
REQ-005 MEM_Enable_signal  input  1  memory request valid.
REQ-006 MEM_RW_enable  input  1  0 = read, 1 = write.
REQ-007 MEM_Size_enable  input  1  0 = byte, 1 = word.
REQ-008 MEM_load_instr  input  1  request belongs to a load instruction.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data.
REQ-011 rdata  output  32  registered read data.
REQ-012 busy  output  1  access in progress; upstream holds the request while high.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 ld_valid  output  1  one-cycle pulse: completed access was a load read; rdata valid for writeback.
REQ-015 align_err  output  1  one-cycle pulse: misaligned word access (see Configuration).

Function
REQ-016 FSM states IDLE, WAIT, ACCESS; request accepted only in IDLE on a rising edge with MEM_Enable_signal=1.
REQ-017 Accept captures addr, wdata, RW, Size and load_instr, loads the wait counter with WAIT_CYCLES, and moves to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
REQ-018 WAIT decrements the counter once per edge; moves to ACCESS on the edge where the counter reaches 0.
REQ-019 ACCESS performs the array operation and returns to IDLE on the same edge; for accept edge E0, the access occurs at edge E0+WAIT_CYCLES+1.
REQ-020 done is high exactly one cycle after the access edge; ld_valid = done AND captured RW=0 AND captured load_instr=1.
REQ-021 busy is high from the edge after accept through the access edge, and low while done is high.
REQ-022 MEM_Enable_signal while busy is ignored, with no capture or side effects.
REQ-023 Back-to-back accesses: a request present in the done cycle is accepted (IDLE), so one access completes every WAIT_CYCLES+2 cycles.
REQ-024 Byte order is big-endian: word at address a = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
REQ-025 Byte read returns rdata = {24'b0, mem[a]}, zero-extended; word read returns the four-byte word.
REQ-026 Byte write stores wdata[7:0] at mem[a]; word write stores all four bytes big-endian.
REQ-027 A write leaves rdata unchanged.
REQ-028 The array index is address modulo DEPTH; out-of-range addresses wrap.

Reset
REQ-029 When R=1: state IDLE, counter 0, rdata 0, busy 0, done 0, ld_valid 0, align_err 0.
REQ-030 R during WAIT or ACCESS aborts the access, with no array write and no done pulse.
REQ-031 R does not initialise array contents.

Configuration
REQ-032 Macro DMEM_ALIGN_CHECK_EN.
REQ-033 When defined, a word access with addr[1:0]!=0:
- pulses align_err together with done;
- suppresses any array write;
- returns rdata 0 on a read.
REQ-034 When undefined, addr[1:0] is forced to 0 for word accesses and align_err is tied 0.

Structure
REQ-035 Shared package dmem_pkg holds the FSM state encoding, SIZE_BYTE/SIZE_WORD and RW_READ/RW_WRITE constants.
REQ-036 One sub-module, dmem_array: byte-wide synchronous-write storage with a four-byte read port.

Verification
REQ-037 WAIT_CYCLES=1; word write 0xDEADBEEF to 0x10, then word read of 0x10 -> done 3 cycles after each accept; rdata=0xDEADBEEF; ld_valid=1 when load_instr=1.
REQ-038 After REQ-037, byte read of 0x11 -> rdata=0x000000AD; byte write 0x55 to 0x13, then word read -> 0xDEADBE55.
REQ-039 Toggle MEM_Enable_signal with new addr while busy -> ignored; completed access uses the originally captured addr.
REQ-040 Word read of 0x102 with DEPTH=256:
- with DMEM_ALIGN_CHECK_EN: align_err=1, rdata=0;
- without it: reads 0x100, whose array index wraps to 0x00.
REQ-041 Assert R for one cycle during WAIT of a write to 0x20 -> outputs zero, no done pulse, later read of 0x20 returns the prior contents.
REQ-042 WAIT_CYCLES=0; continuous back-to-back reads -> done every 2 cycles, busy and done never high together.
